fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the control decoder. Holds PC and instruction register (IR).
//  Presents format/opcode/sign fields to control and consumes its branch/jump/halt outputs.
//  Reads a combinational instruction memory. Squashes the wrong-path fetch after a redirect.
// PARAMETERS
//  PC_W      8       PC / instruction-memory address width
//  INSTR_W   9       instruction width; fields: [8]=format, [7:4]=opcode, [3]=sign, [3:0]=branch offset
//  RESET_PC  0       PC value loaded on reset
//  NOP_INSTR 9'h100  IR content while invalid (bubble, idle, halted)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        level; leaves IDLE when sampled high
//  imem_addr    out  PC_W     = pc (combinational)
//  imem_data    in   INSTR_W  instruction at imem_addr, same cycle
//  format       out  1        ir[8] to control
//  opcode       out  4        ir[7:4] to control
//  sign         out  1        ir[3] to control
//  ir           out  INSTR_W  full instruction register
//  ir_pc        out  PC_W     address the IR was fetched from
//  ir_valid     out  1        IR holds a real instruction; downstream gates regWrite/memWrite with it
//  branch       in   1        from control, decoded from IR
//  jump         in   1        from control
//  halt         in   1        from control
//  cond_flag    in   1        branch condition (taken when 1)
//  jump_target  in   PC_W     absolute jump address from register file
//  stall        in   1        only with FETCH_STALL_EN
//  halted       out  1        high in HALTED
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=NOP_INSTR, ir_pc=0, ir_valid=0, halted=0.
//  FSM: IDLE -start-> RUN; RUN -(ir_valid&halt)-> HALTED; HALTED holds until rst_n. No other transitions.
//  IDLE: pc, ir and ir_pc hold; ir_valid=0.
//  RUN, per clock:
//  - Redirect qualifier: act = ir_valid. Branch/jump/halt are ignored when ir_valid=0.
//  - Priority is halt > jump > taken branch (branch & cond_flag) > sequential.
//  - halt: pc holds; ir=NOP_INSTR; ir_valid=0; state->HALTED; halted=1 from next cycle.
//  - jump: pc<=jump_target; ir=NOP_INSTR; ir_valid=0 (1-cycle bubble).
//  - taken branch: pc<=ir_pc+sext(ir[3:0]), modulo 2^PC_W; ir=NOP_INSTR; ir_valid=0.
//  - otherwise: ir<=imem_data; ir_pc<=pc; ir_valid<=1; pc<=pc+1, wrapping 2^PC_W-1 -> 0.
//  Latency: instruction at address A is visible in IR 1 cycle after pc=A.
//  Redirect penalty: exactly 1 bubble cycle. The target fetch enters IR the cycle after.
//  Not-taken branch (cond_flag=0): no bubble.
//  Branch offset range is -8..+7 relative to ir_pc. Offset 0 loops on itself.
//  Back-to-back redirects are impossible: the bubble has ir_valid=0.
//  HALTED: all registers frozen except ir_valid=0 and halted=1; start ignored.
//  Reset mid-run or while halted returns to IDLE regardless of state.
// CONFIGURATION
//  FETCH_STALL_EN defined:
//  - stall=1 in RUN freezes pc, ir, ir_pc and ir_valid.
//  - Redirects and halt are deferred; they take effect on the first cycle with stall=0.
//  - stall is ignored in IDLE and HALTED.
//  FETCH_STALL_EN undefined: no stall port; fetch advances every RUN cycle.
// TESTING
//  1) Reset, start=1, imem[0..3] non-control ops -> ir_pc=0,1,2,3 on consecutive cycles; ir_valid=1 from cycle 2.
//  2) imem[5]=branch with offset -3, cond_flag=1 -> cycle after: ir_valid=0; then ir_pc=2.
//     Same with cond_flag=0 -> ir_pc=6, no bubble.
//  3) imem[4]=jump, jump_target=8'hF0 -> 1 bubble, then ir_pc=8'hF0.
//     Run to 8'hFF -> next ir_pc=8'h00 (wrap).
//  4) halt and jump asserted together at ir_pc=7 -> HALTED, halted=1, pc=8.
//     Toggling start 10 cycles -> no change.
//  5) rst_n low mid-run, asynchronous to clk -> outputs at reset values immediately; IDLE until start.
//  6) FETCH_STALL_EN: stall=1 for 3 cycles while IR holds a jump -> IR/pc frozen; jump applied on release.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with redirect squash and halt.
// Optional FETCH_STALL_EN adds a stall input that freezes fetch in RUN.
module fetch_unit #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 9'h100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               format,
  output logic [3:0]         opcode,
  output logic               sign,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               branch,
  input  logic               jump,
  input  logic               halt,
  input  logic               cond_flag,
  input  logic [PC_W-1:0]    jump_target,
`ifdef FETCH_STALL_EN
  input  logic               stall,
`endif
  output logic               halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_d;
  logic [PC_W-1:0] pc, pc_d, ir_pc_d;
  logic [INSTR_W-1:0] ir_d;
  logic ir_valid_d, frz;
`ifdef FETCH_STALL_EN
  assign frz = stall;
`else
  assign frz = 1'b0;
`endif
  assign imem_addr = pc;
  assign format = ir[8];
  assign opcode = ir[7:4];
  assign sign = ir[3];
  assign halted = state == HALTED;
  // redirects only act on a valid IR, so the bubble itself can never redirect
  always_comb begin
    state_d = state;
    pc_d = pc;
    ir_d = ir;
    ir_pc_d = ir_pc;
    ir_valid_d = 1'b0;
    if (state == IDLE) state_d = start ? RUN : IDLE;
    else if (state == RUN && frz) ir_valid_d = ir_valid;
    else if (state == RUN) begin
      if (ir_valid && halt) begin
        state_d = HALTED;
        ir_d = NOP_INSTR;
      end else if (ir_valid && (jump || (branch && cond_flag))) begin
        pc_d = jump ? jump_target : ir_pc + {{(PC_W-4){ir[3]}}, ir[3:0]};
        ir_d = NOP_INSTR;
      end else begin
        ir_d = imem_data;
        ir_pc_d = pc;
        ir_valid_d = 1'b1;
        pc_d = pc + PC_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= NOP_INSTR;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      ir <= ir_d;
      ir_pc <= ir_pc_d;
      ir_valid <= ir_valid_d;
    end
endmodule
